axi_lite_initiator: RTL and testbench

Single-outstanding AXI4-Lite initiator. It turns simple command requests (read or write, with address, data and strobe) into AXI4-Lite transactions toward a slave such as `axi_vga`. It returns each completion to the requester as a one-entry response. It is the master-side counterpart of the existing AXI-Lite slave path, and it replaces bench-level bus driving wherever a synthesizable initiator is needed.

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_init_timeout.sv | 37 +++
 rtl/axi_lite_initiator.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_lite_initiator.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite initiator: FSM states, response codes,
// default bus widths and the fixed PROT value.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int AXI_ADDR_W_DEF = 15;
  localparam int AXI_DATA_W_DEF = 32;

  localparam logic [2:0] AXI_PROT = 3'b000;

endpackage

// File: rtl/axi_init_timeout.sv
// Saturating per-transaction cycle counter; expired stays high once LIMIT is
// reached until the next clear.
module axi_init_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT_C)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT_C);

endmodule

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4-Lite master: one command in, one response out.
// Optional watchdog abort is compiled in with AXI_INIT_TIMEOUT_EN.
module axi_lite_initiator
  import axi_lite_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = AXI_ADDR_W_DEF,
  parameter int C_AXI_DATA_WIDTH = AXI_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_we,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP
);

  localparam int SW = C_AXI_DATA_WIDTH / 8;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                      state_q, state_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]               wstrb_q, wstrb_d;
  logic                        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                        awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                        bready_q, bready_d, arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                  rsp_resp_q, rsp_resp_d;
  logic                        accept;

  assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;

`ifdef AXI_INIT_TIMEOUT_EN
  logic tmo_enable, tmo_expired, rsp_timeout_q, rsp_timeout_d;

  assign tmo_enable = !(state_q inside {IDLE, RESP});

  axi_init_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .clear   (accept),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = 1'b0;
    arvalid_d   = arvalid_q;
    rready_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXI_INIT_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_we) begin
            state_d   = WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_ADDR_DATA: begin
        // AW and W retire independently; each VALID drops after its own handshake.
        aw_done_d = aw_done_q | (awvalid_q & M_AXI_AWREADY);
        w_done_d  = w_done_q | (wvalid_q & M_AXI_WREADY);
        awvalid_d = !aw_done_d;
        wvalid_d  = !w_done_d;
        if (aw_done_d && w_done_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        bready_d = 1'b1;
        if (bready_q && M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
`ifdef AXI_INIT_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d = RESP;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        rready_d = 1'b1;
        if (rready_q && M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
`ifdef AXI_INIT_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_INIT_TIMEOUT_EN
    // Watchdog abort deliberately overrides any in-flight handshake.
    if (tmo_enable && tmo_expired) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      state_d       = RESP;
    end
`endif
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
`ifdef AXI_INIT_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXI_INIT_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
`ifdef AXI_INIT_TIMEOUT_EN
  assign rsp_timeout   = rsp_timeout_q;
`else
  assign rsp_timeout   = 1'b0;
`endif
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Directed bench for axi_lite_initiator with a configurable-latency AXI4-Lite
// slave model; covers the timeout path only when AXI_INIT_TIMEOUT_EN is defined.
module tb_axi_lite_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [14:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [14:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // slave model configuration
  int          s_w_wait = 0;
  int          s_r_wait = 0;
  bit          s_hang = 1'b0;
  bit          s_b_hold = 1'b0;
  logic [1:0]  s_bresp = 2'b00;
  logic [1:0]  s_rresp = 2'b00;
  logic [31:0] s_rdata = '0;

  // slave model state and observations
  int          w_cnt, r_cnt;
  bit          aw_got, w_got, r_pend;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_aw_viol = 0, n_w_viol = 0;
  logic [14:0] cap_awaddr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  axi_lite_initiator dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [113:0] all_outs = {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
                           M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR,
                           rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready,
                           M_AXI_AWPROT, M_AXI_ARPROT};

  // AW is always immediately ready; W becomes ready s_w_wait cycles after WVALID rises.
  assign M_AXI_AWREADY = !s_hang && M_AXI_AWVALID;
  assign M_AXI_WREADY  = !s_hang && M_AXI_WVALID && (w_cnt >= s_w_wait);
  assign M_AXI_ARREADY = !s_hang && M_AXI_ARVALID;
  wire aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  wire w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  wire ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt <= 0; r_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0; M_AXI_RRESP <= 2'b00;
    end else begin
      w_cnt <= (!M_AXI_WVALID || M_AXI_WREADY) ? 0 : w_cnt + 1;
      if (M_AXI_AWVALID && aw_got) n_aw_viol <= n_aw_viol + 1;
      if (M_AXI_WVALID && w_got) n_w_viol <= n_w_viol + 1;
      if (aw_hs) begin aw_got <= 1'b1; cap_awaddr <= M_AXI_AWADDR; n_aw <= n_aw + 1; end
      if (w_hs) begin
        w_got <= 1'b1; cap_wdata <= M_AXI_WDATA; cap_wstrb <= M_AXI_WSTRB; n_w <= n_w + 1;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !M_AXI_BVALID && !s_b_hold) begin
        M_AXI_BVALID <= 1'b1; M_AXI_BRESP <= s_bresp; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin M_AXI_BVALID <= 1'b0; n_b <= n_b + 1; end
      if (ar_hs) begin
        n_ar <= n_ar + 1;
        if (s_r_wait == 0) begin
          M_AXI_RVALID <= 1'b1; M_AXI_RDATA <= s_rdata; M_AXI_RRESP <= s_rresp;
        end else begin
          r_pend <= 1'b1; r_cnt <= s_r_wait - 1;
        end
      end else if (r_pend) begin
        if (r_cnt == 0) begin
          M_AXI_RVALID <= 1'b1; M_AXI_RDATA <= s_rdata; M_AXI_RRESP <= s_rresp; r_pend <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin M_AXI_RVALID <= 1'b0; n_r <= n_r + 1; end
    end
  end

  // Drives one command and returns #1 after its accepting edge.
  task automatic send_cmd(input logic we, input logic [14:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int acc_cyc);
    cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin @(posedge clk); #1; acc_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (acc_cyc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept: got no accept within 50 cycles, required accept");
    end
  endtask

  task automatic wait_rsp(input int budget, output int rsp_cyc);
    rsp_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid) begin rsp_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    if (rsp_cyc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_wait: got no rsp_valid within %0d cycles, required rsp_valid", budget);
    end
  endtask

  task automatic ack_rsp(input string tag);
    $display("txn %s: rdata=%08h resp=%0b timeout=%0b cyc=%0d", tag, rsp_rdata, rsp_resp,
             rsp_timeout, cyc);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, required 0", all_outs);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
    $display("txn reset: released at cyc=%0d", cyc);
  endtask

  task automatic test_write_zero_wait();
    int acc, rc;
    s_w_wait = 0; s_bresp = 2'b00;
    send_cmd(1'b1, 15'h4000, 32'hFFFF_FFFF, 4'b0001, acc);
    n_checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WSTRB, M_AXI_AWPROT} !==
        {2'b11, 15'h4000, 4'b0001, 3'b000}) begin
      n_fail++;
      $display("FAIL wr0_channels: got aw=%b w=%b addr=%h strb=%b prot=%b, required 1 1 4000 0001 000",
               M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WSTRB, M_AXI_AWPROT);
    end
    wait_rsp(20, rc);
    // accept edge N; rsp_valid registered on edge N+2, i.e. visible in cycle N+3
    n_checks++;
    if (rc - acc !== 2) begin
      n_fail++; $display("FAIL wr0_latency: got %0d edges after accept, required 2", rc - acc);
    end
    n_checks++;
    if ({rsp_resp, rsp_rdata, rsp_timeout} !== {2'b00, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL wr0_rsp: got resp=%b rdata=%h to=%b, required 00 0 0",
                         rsp_resp, rsp_rdata, rsp_timeout);
    end
    n_checks++;
    if ({cap_awaddr, cap_wdata, cap_wstrb} !== {15'h4000, 32'hFFFF_FFFF, 4'b0001}) begin
      n_fail++; $display("FAIL wr0_slave_capture: got %h %h %b, required 4000 ffffffff 0001",
                         cap_awaddr, cap_wdata, cap_wstrb);
    end
    ack_rsp("write 0x4000");
  endtask

  task automatic test_write_skewed();
    int acc, rc, b0, aw0, w0;
    s_w_wait = 3; s_bresp = 2'b10;
    b0 = n_b; aw0 = n_aw; w0 = n_w;
    send_cmd(1'b1, 15'h495C, 32'h1234_5678, 4'b1111, acc);
    @(posedge clk); #1;
    n_checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b01) begin
      n_fail++; $display("FAIL wrskew_aw_drop: got aw=%b w=%b, required aw=0 w=1",
                         M_AXI_AWVALID, M_AXI_WVALID);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (M_AXI_WVALID !== 1'b1) begin
      n_fail++; $display("FAIL wrskew_w_hold: got wvalid=%b, required 1", M_AXI_WVALID);
    end
    wait_rsp(20, rc);
    n_checks++;
    if ({n_aw - aw0, n_w - w0, n_b - b0, n_aw_viol, n_w_viol} !== {32'd1, 32'd1, 32'd1, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL wrskew_handshakes: got aw=%0d w=%0d b=%0d awviol=%0d wviol=%0d, required 1 1 1 0 0",
                         n_aw - aw0, n_w - w0, n_b - b0, n_aw_viol, n_w_viol);
    end
    n_checks++;
    if ({rsp_resp, rsp_rdata} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL wrskew_rsp: got resp=%b rdata=%h, required 10 0", rsp_resp, rsp_rdata);
    end
    ack_rsp("write 0x495C skewed");
    s_w_wait = 0; s_bresp = 2'b00;
  endtask

  task automatic test_read();
    int acc, rc, r0;
    s_r_wait = 4; s_rdata = 32'h6619_1966; s_rresp = 2'b00;
    r0 = n_r;
    send_cmd(1'b0, 15'h495C, 32'h0, 4'b0000, acc);
    n_checks++;
    if ({M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_AWVALID} !== {1'b1, 15'h495C, 3'b000, 1'b0}) begin
      n_fail++; $display("FAIL rd_ar: got arvalid=%b araddr=%h prot=%b awvalid=%b, required 1 495c 000 0",
                         M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_AWVALID);
    end
    wait_rsp(30, rc);
    // AR at edge N+1, RVALID after edge N+5, captured at edge N+6
    n_checks++;
    if (rc - acc !== 6) begin
      n_fail++; $display("FAIL rd_latency: got %0d edges after accept, required 6", rc - acc);
    end
    n_checks++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== {32'h6619_1966, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL rd_rsp: got rdata=%h resp=%b to=%b, required 66191966 00 0",
                         rsp_rdata, rsp_resp, rsp_timeout);
    end
    n_checks++;
    if (n_r - r0 !== 1) begin
      n_fail++; $display("FAIL rd_r_count: got %0d R handshakes, required 1", n_r - r0);
    end
    ack_rsp("read 0x495C");
    s_r_wait = 0;
  endtask

  task automatic test_back_to_back();
    int acc, rc, busy_ready, hold_bad;
    s_bresp = 2'b11; s_rdata = 32'hCAFE_F00D; s_rresp = 2'b00;
    busy_ready = 0; hold_bad = 0;
    send_cmd(1'b1, 15'h0010, 32'hA5A5_A5A5, 4'b1111, acc);
    cmd_we = 1'b0; cmd_addr = 15'h0020; cmd_valid = 1'b1;
    rc = -1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) busy_ready++;
      if (rsp_valid) begin rc = cyc; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (rc < 0) begin
      n_fail++; $display("FAIL b2b_rsp1_wait: got no rsp_valid in 20 cycles, required rsp_valid");
    end
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid, rsp_resp, rsp_rdata, cmd_ready} !== {1'b1, 2'b11, 32'h0, 1'b0}) hold_bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if ({busy_ready, hold_bad} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL b2b_hold: got cmd_ready-while-busy=%0d unstable-cycles=%0d, required 0 0",
                         busy_ready, hold_bad);
    end
    ack_rsp("b2b write 0x0010");
    n_checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_idle: got cmd_ready=%b rsp_valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++;
    if ({cmd_ready, M_AXI_ARVALID, M_AXI_ARADDR} !== {1'b0, 1'b1, 15'h0020}) begin
      n_fail++; $display("FAIL b2b_second_accept: got cmd_ready=%b arvalid=%b araddr=%h, required 0 1 0020",
                         cmd_ready, M_AXI_ARVALID, M_AXI_ARADDR);
    end
    wait_rsp(20, rc);
    n_checks++;
    if ({rsp_rdata, rsp_resp} !== {32'hCAFE_F00D, 2'b00}) begin
      n_fail++; $display("FAIL b2b_rsp2: got rdata=%h resp=%b, required cafef00d 00", rsp_rdata, rsp_resp);
    end
    ack_rsp("b2b read 0x0020");
    s_bresp = 2'b00;
  endtask

  task automatic test_timeout();
    int acc;
    s_hang = 1'b1;
    send_cmd(1'b1, 15'h0100, 32'h0BAD_0BAD, 4'b1111, acc);
`ifdef AXI_INIT_TIMEOUT_EN
    begin
      int rc;
      wait_rsp(40, rc);
      // counter reaches 16 after edge N+16; the abort lands on edge N+17
      n_checks++;
      if (rc - acc !== 17) begin
        n_fail++; $display("FAIL tmo_latency: got %0d edges after accept, required 17", rc - acc);
      end
      n_checks++;
      if ({rsp_timeout, rsp_resp, rsp_rdata, M_AXI_AWVALID, M_AXI_WVALID} !== {1'b1, 2'b10, 32'h0, 2'b00}) begin
        n_fail++; $display("FAIL tmo_rsp: got to=%b resp=%b rdata=%h aw=%b w=%b, required 1 10 0 0 0",
                           rsp_timeout, rsp_resp, rsp_rdata, M_AXI_AWVALID, M_AXI_WVALID);
      end
      ack_rsp("write 0x0100 timeout");
      s_hang = 1'b0;
    end
`else
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, rsp_valid, rsp_timeout} !== 4'b1100) begin
      n_fail++; $display("FAIL hang_wait: got aw=%b w=%b rsp_valid=%b to=%b, required 1 1 0 0",
                         M_AXI_AWVALID, M_AXI_WVALID, rsp_valid, rsp_timeout);
    end
    $display("txn write 0x0100 hang: still waiting at cyc=%0d", cyc);
    s_hang = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid();
    int acc, seen;
    s_b_hold = 1'b1; seen = 0;
    send_cmd(1'b1, 15'h0200, 32'h5555_AAAA, 4'b1010, acc);
    @(posedge clk); #1;
    n_checks++;
    if (M_AXI_BREADY !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_wr_resp: got bready=%b, required 1", M_AXI_BREADY);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL rstmid_async_outputs: got %h, required 0", all_outs);
    end
    s_b_hold = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_cmd_ready: got %b, required 1", cmd_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL rstmid_no_rsp: got rsp_valid for %0d cycles, required 0", seen);
    end
    $display("txn write 0x0200 aborted by reset at cyc=%0d", cyc);
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_write_skewed();
    test_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
